cpu_control_unit: RTL and testbench

- Fetch/decode/execute sequencer for the 4-bit simple CPU, directly upstream of the ALU.
- Holds the program counter, instruction register and accumulator.
- Drives the ALU's A operand (accumulator) and ALU_OP, and fetches the M operand address.
- Captures the ALU result X back into the accumulator.

---
 rtl/cpu_control_unit.sv | 124 ++++++++++++
 tb/tb_cpu_control_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: PC, IR and ACC.
// Optional single-step mode (STEP input, PAUSE state) under CTRL_SINGLE_STEP_EN.
module cpu_control_unit #(
  parameter int PC_W   = 4,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              STEP,
`endif
  input  logic [7:0]        INSTR,
  output logic [PC_W-1:0]   PC,
  output logic [3:0]        MEM_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [2:0]        ALU_OP,
  input  logic [DATA_W-1:0] ALU_X,
  output logic [DATA_W-1:0] ACC,
  output logic              BUSY,
  output logic              HALTED
);

`ifdef CTRL_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_PAUSE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_t;
`endif

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_next;
  logic [7:0]          r_ir;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   w_acc_next;
  logic [3:0]          w_opc;
  logic [3:0]          w_opnd;
  logic [PC_W-1:0]     w_opnd_pc;
  logic [DATA_W-1:0]   w_opnd_d;
  logic                w_we;
  logic [2:0]          w_alu_op;

  assign w_opc     = r_ir[7:4];
  assign w_opnd    = r_ir[3:0];
  assign w_opnd_pc = PC_W'(w_opnd);
  assign w_opnd_d  = DATA_W'(w_opnd);

  always_comb begin
    w_next     = r_state;
    w_pc_next  = r_pc;
    w_acc_next = r_acc;
    w_we       = 1'b0;
    w_alu_op   = 3'b000;
    case (r_state)
      S_IDLE:   if (START) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
`ifdef CTRL_SINGLE_STEP_EN
        w_next = S_PAUSE;
`else
        w_next = S_FETCH;
`endif
        w_pc_next = r_pc + PC_ONE;
        if (!w_opc[3]) begin
          w_alu_op   = w_opc[2:0];
          w_acc_next = ALU_X;
        end else begin
          case (w_opc)
            4'h8: w_acc_next = w_opnd_d;
            4'h9: w_we = 1'b1;
            4'hA: w_pc_next = w_opnd_pc;
            4'hB: if (r_acc == '0) w_pc_next = w_opnd_pc;
            4'hF: begin
              w_pc_next = r_pc;
              w_next    = S_HALT;
            end
            default: ;
          endcase
        end
      end
      S_HALT: ;
`ifdef CTRL_SINGLE_STEP_EN
      S_PAUSE: if (STEP) w_next = S_FETCH;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_acc   <= w_acc_next;
      if (r_state == S_FETCH) r_ir <= INSTR;
    end
  end

  // Data address is only presented while the operand is live.
  assign MEM_ADDR  = (r_state == S_DECODE || r_state == S_EXEC)
                     ? w_opnd : 4'h0;
  assign MEM_WE    = w_we;
  assign MEM_WDATA = r_acc;
  assign ALU_OP    = w_alu_op;
  assign PC        = r_pc;
  assign ACC       = r_acc;
  assign BUSY      = (r_state == S_FETCH) || (r_state == S_DECODE)
                     || (r_state == S_EXEC);
  assign HALTED    = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction-level reference model,
// bench-side ALU and memories, directed and random programs.
module tb_cpu_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] INSTR;
  logic [3:0] PC;
  logic [3:0] MEM_ADDR;
  logic       MEM_WE;
  logic [3:0] MEM_WDATA;
  logic [2:0] ALU_OP;
  logic [3:0] ALU_X;
  logic [3:0] ACC;
  logic       BUSY;
  logic       HALTED;

  logic [7:0] imem [16];
  logic [3:0] dmem [16];
  logic [3:0] load_img [16];
  logic       load_en;

  logic [3:0] m_pc;
  logic [3:0] m_acc;
  logic       m_halt;
  logic [3:0] m_dmem [16];

  int n_pass = 0;
  int n_total = 0;

  cpu_control_unit #(.PC_W(4), .DATA_W(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .INSTR(INSTR),
    .PC(PC), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
    .MEM_WDATA(MEM_WDATA), .ALU_OP(ALU_OP), .ALU_X(ALU_X),
    .ACC(ACC), .BUSY(BUSY), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] alu(input logic [2:0] op,
                                     input logic [3:0] a,
                                     input logic [3:0] m);
    case (op)
      3'd0: return m;
      3'd1: return a + m;
      3'd2: return a - m;
      3'd3: return a & m;
      3'd4: return a | m;
      3'd5: return a ^ m;
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  assign INSTR = imem[PC];
  assign ALU_X = alu(ALU_OP, ACC, dmem[MEM_ADDR]);

  always @(posedge CLK) begin
    if (load_en) dmem <= load_img;
    else if (MEM_WE) dmem[MEM_ADDR] <= MEM_WDATA;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_imem(input logic [7:0] v);
    for (int i = 0; i < 16; i++) imem[i] = v;
  endtask

  task automatic load_mem;
    load_en = 1'b1;
    tick;
    load_en = 1'b0;
    m_dmem = load_img;
  endtask

  task automatic clear_img;
    for (int i = 0; i < 16; i++) load_img[i] = 4'h0;
  endtask

  task automatic do_reset;
    #2 RST = 1'b1;
    #1;
    n_total++;
    if ({PC, ACC, ALU_OP, MEM_WE, BUSY, HALTED, MEM_ADDR} !== 18'h0)
      $display("FAIL reset_async: got pc=%h acc=%h op=%h we=%b busy=%b halt=%b addr=%h want all 0",
               PC, ACC, ALU_OP, MEM_WE, BUSY, HALTED, MEM_ADDR);
    else n_pass++;
    tick;
    RST = 1'b0;
    m_pc = 4'h0;
    m_acc = 4'h0;
    m_halt = 1'b0;
  endtask

  task automatic pulse_start;
    START = 1'b1;
    tick;
    START = 1'b0;
  endtask

  task automatic run_instr(input logic hold);
    logic [7:0] ins;
    logic [2:0] e_op;
    logic       e_we;
    ins = imem[m_pc];
    e_op = ins[7] ? 3'b000 : ins[6:4];
    e_we = (ins[7:4] == 4'h9);
    START = hold;
    n_total++;
    if ({BUSY, MEM_WE, ALU_OP} !== 5'b10000)
      $display("FAIL fetch_ctl: got busy=%b we=%b op=%h want 1 0 0",
               BUSY, MEM_WE, ALU_OP);
    else n_pass++;
    tick;
    n_total++;
    if ({BUSY, MEM_WE, ALU_OP, MEM_ADDR} !== {1'b1, 1'b0, 3'b0, ins[3:0]})
      $display("FAIL decode_ctl: got busy=%b we=%b op=%h addr=%h want 1 0 0 %h",
               BUSY, MEM_WE, ALU_OP, MEM_ADDR, ins[3:0]);
    else n_pass++;
    tick;
    n_total++;
    if ({BUSY, MEM_WE, ALU_OP, MEM_ADDR, MEM_WDATA} !==
        {1'b1, e_we, e_op, ins[3:0], m_acc})
      $display("FAIL exec_ctl: ins=%h got we=%b op=%h addr=%h wd=%h want %b %h %h %h",
               ins, MEM_WE, ALU_OP, MEM_ADDR, MEM_WDATA,
               e_we, e_op, ins[3:0], m_acc);
    else n_pass++;
    tick;
    if (!ins[7]) begin
      m_acc = alu(ins[6:4], m_acc, m_dmem[ins[3:0]]);
      m_pc = m_pc + 4'h1;
    end else begin
      case (ins[7:4])
        4'h8: begin m_acc = ins[3:0]; m_pc = m_pc + 4'h1; end
        4'h9: begin m_dmem[ins[3:0]] = m_acc; m_pc = m_pc + 4'h1; end
        4'hA: m_pc = ins[3:0];
        4'hB: m_pc = (m_acc == 4'h0) ? ins[3:0] : m_pc + 4'h1;
        4'hF: m_halt = 1'b1;
        default: m_pc = m_pc + 4'h1;
      endcase
    end
    n_total++;
    if ({PC, ACC, HALTED, BUSY} !== {m_pc, m_acc, m_halt, ~m_halt})
      $display("FAIL commit: ins=%h got pc=%h acc=%h halt=%b busy=%b want %h %h %b %b",
               ins, PC, ACC, HALTED, BUSY, m_pc, m_acc, m_halt, ~m_halt);
    else n_pass++;
    if (m_halt) begin
      n_total++;
      if (MEM_ADDR !== 4'h0)
        $display("FAIL halt_addr: got %h want 0", MEM_ADDR);
      else n_pass++;
    end
  endtask

  task automatic run_prog(input int max_n, input logic hold);
    for (int i = 0; i < max_n && !m_halt; i++) run_instr(hold);
    START = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) imem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) load_img[i] = 4'($urandom);
    load_mem;
    pulse_start;
    run_prog(2, 1'b0);
    tick;
    do_reset;
  endtask

  task automatic test_program;
    fill_imem(8'hC0);
    imem[0] = 8'h85; imem[1] = 8'h12; imem[2] = 8'hF0;
    clear_img;
    load_img[2] = 4'h3;
    load_mem;
    pulse_start;
    run_instr(1'b0);
    run_instr(1'b0);
    n_total++;
    if (ACC !== 4'h8) $display("FAIL add_acc: got %h want 8", ACC);
    else n_pass++;
    run_instr(1'b0);
    n_total++;
    if ({HALTED, PC} !== {1'b1, 4'h2})
      $display("FAIL hlt: got halt=%b pc=%h want 1 2", HALTED, PC);
    else n_pass++;
    pulse_start;
    tick;
    n_total++;
    if ({HALTED, BUSY, PC} !== {1'b1, 1'b0, 4'h2})
      $display("FAIL halt_start: got halt=%b busy=%b pc=%h want 1 0 2",
               HALTED, BUSY, PC);
    else n_pass++;
    do_reset;
  endtask

  task automatic test_jz;
    fill_imem(8'hC0);
    imem[0] = 8'h80; imem[1] = 8'hB7; imem[7] = 8'hF0;
    pulse_start;
    run_instr(1'b0);
    run_instr(1'b0);
    n_total++;
    if (PC !== 4'h7) $display("FAIL jz_taken: got pc=%h want 7", PC);
    else n_pass++;
    run_prog(4, 1'b0);
    do_reset;
    imem[0] = 8'h81;
    pulse_start;
    run_instr(1'b0);
    run_instr(1'b0);
    n_total++;
    if (PC !== 4'h2) $display("FAIL jz_not_taken: got pc=%h want 2", PC);
    else n_pass++;
    do_reset;
  endtask

  task automatic test_sta;
    fill_imem(8'hF0);
    imem[0] = 8'h8A; imem[1] = 8'h94;
    clear_img;
    load_mem;
    pulse_start;
    run_prog(4, 1'b0);
    n_total++;
    if (dmem[4] !== 4'hA) $display("FAIL sta_mem: got %h want a", dmem[4]);
    else n_pass++;
    do_reset;
  endtask

  task automatic test_wrap_sub;
    fill_imem(8'hC0);
    imem[0] = 8'hAF;
    pulse_start;
    run_instr(1'b0);
    run_instr(1'b0);
    n_total++;
    if (PC !== 4'h0) $display("FAIL pc_wrap: got pc=%h want 0", PC);
    else n_pass++;
    do_reset;
    imem[0] = 8'h81; imem[1] = 8'h22; imem[2] = 8'hF0;
    clear_img;
    load_img[2] = 4'h2;
    load_mem;
    pulse_start;
    run_prog(4, 1'b0);
    n_total++;
    if (ACC !== 4'hF) $display("FAIL sub_wrap: got acc=%h want f", ACC);
    else n_pass++;
    do_reset;
  endtask

  task automatic test_reset_exec;
    fill_imem(8'hF0);
    imem[0] = 8'h8A; imem[1] = 8'h94;
    clear_img;
    load_img[4] = 4'h5;
    load_mem;
    pulse_start;
    run_instr(1'b0);
    tick;
    tick;
    n_total++;
    if (MEM_WE !== 1'b1) $display("FAIL sta_exec_we: got %b want 1", MEM_WE);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_total++;
    if ({MEM_WE, BUSY, HALTED, PC, ACC} !== 11'h0)
      $display("FAIL reset_in_exec: got we=%b busy=%b halt=%b pc=%h acc=%h want 0",
               MEM_WE, BUSY, HALTED, PC, ACC);
    else n_pass++;
    tick;
    RST = 1'b0;
    tick;
    n_total++;
    if ({dmem[4], BUSY} !== {4'h5, 1'b0})
      $display("FAIL reset_no_write: got mem=%h busy=%b want 5 0", dmem[4], BUSY);
    else n_pass++;
    m_pc = 4'h0; m_acc = 4'h0; m_halt = 1'b0;
    do_reset;
  endtask

  task automatic test_start_busy;
    fill_imem(8'hC0);
    imem[0] = 8'h85; imem[1] = 8'h12; imem[2] = 8'hF0;
    clear_img;
    load_img[2] = 4'h3;
    load_mem;
    pulse_start;
    run_prog(6, 1'b1);
    n_total++;
    if ({HALTED, PC, ACC} !== {1'b1, 4'h2, 4'h8})
      $display("FAIL start_busy: got halt=%b pc=%h acc=%h want 1 2 8",
               HALTED, PC, ACC);
    else n_pass++;
    do_reset;
  endtask

  task automatic test_random;
    int bad;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) imem[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) load_img[i] = 4'($urandom);
      load_mem;
      pulse_start;
      run_prog(24, 1'b0);
      bad = 0;
      for (int i = 0; i < 16; i++) if (dmem[i] !== m_dmem[i]) bad++;
      n_total++;
      if (bad != 0) $display("FAIL rand_dmem: got %0d differing words want 0", bad);
      else n_pass++;
      do_reset;
    end
  endtask

  initial begin
    RST = 1'b0;
    START = 1'b0;
    load_en = 1'b0;
    fill_imem(8'hC0);
    clear_img;
    #1;
    do_reset;
    test_reset;
    test_program;
    test_jz;
    test_sta;
    test_wrap_sub;
    test_reset_exec;
    test_start_busy;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
